// File: rtl/matrix_stream_loader_pkg.sv
// Shared constants and helpers for the matrix stream loader and its bank storage.
package matrix_stream_loader_pkg;

    localparam int DATA_WIDTH_DEF  = 8;
    localparam int MATRIX_SIZE_DEF = 25;
    localparam int MATRIX_DIM      = 5;

    // Width of an index able to address n elements (at least one bit).
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // LSB position of element k inside a packed matrix.
    function automatic int elem_lsb(input int k, input int dw);
        return k * dw;
    endfunction

endpackage

// File: rtl/matrix_bank.sv
// One matrix worth of element storage with an indexed element write and a full flag.
// Writes land on the next clock edge; full set/clear are never requested together.
module matrix_bank
    import matrix_stream_loader_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int MATRIX_SIZE = MATRIX_SIZE_DEF,
    localparam int IW = idx_width(MATRIX_SIZE),
    localparam int MW = MATRIX_SIZE * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [IW-1:0]         wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    input  logic                  set_full,
    input  logic                  clr_full,
    output logic [MW-1:0]         mat,
    output logic                  full
);

    logic [MW-1:0] mat_q, mat_d;
    logic          full_q, full_d;

    always_comb begin
        mat_d  = mat_q;
        full_d = full_q;
        for (int k = 0; k < MATRIX_SIZE; k++) begin
            if (wr_en && (wr_idx == IW'(k))) begin
                mat_d[elem_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = wr_dat;
            end
        end
        if (set_full) begin
            full_d = 1'b1;
        end else if (clr_full) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat_q  <= '0;
            full_q <= 1'b0;
        end else begin
            mat_q  <= mat_d;
            full_q <= full_d;
        end
    end

    assign mat  = mat_q;
    assign full = full_q;

endmodule

// File: rtl/matrix_stream_loader.sv
// Packs a row-major element stream into a flat matrix bus through a ping-pong pair of banks.
// s_ready depends only on registered state; a frame may complete while the other bank drains.
module matrix_stream_loader
    import matrix_stream_loader_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int MATRIX_SIZE = MATRIX_SIZE_DEF,
    localparam int IW = idx_width(MATRIX_SIZE),
    localparam int MW = MATRIX_SIZE * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_last,
    output logic [MW-1:0]         m_mat,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  err_len
);

    localparam logic [IW-1:0] LAST_IDX = IW'(MATRIX_SIZE - 1);

    logic [IW-1:0] idx_q, idx_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic          err_q, err_d;
    logic          init_q, init_d;

    logic          acc, at_last, complete, drain;
    logic [1:0]    bank_wr_en, bank_set, bank_clr, bank_full;
    logic [MW-1:0] bank_mat [2];

    assign s_ready = init_q && !bank_full[wr_ptr_q];
    assign m_valid = bank_full[rd_ptr_q];
    // With nothing pending, the bank opposite the read pointer is the one last drained,
    // and the writer cannot touch it until the next matrix is presented.
    assign m_mat   = m_valid ? bank_mat[rd_ptr_q] : bank_mat[~rd_ptr_q];
    assign err_len = err_q;

    always_comb begin
        acc      = s_valid && s_ready;
        at_last  = (idx_q == LAST_IDX);
        complete = acc && at_last;
        drain    = m_valid && m_ready;

        idx_d = idx_q;
        if (acc) begin
            idx_d = (at_last || s_last) ? '0 : idx_q + IW'(1);
        end
        wr_ptr_d = wr_ptr_q ^ complete;
        rd_ptr_d = rd_ptr_q ^ drain;
        // Early last or missing last: the two flags disagree on the accepted beat.
        err_d    = acc && (at_last != s_last);
        init_d   = 1'b1;

        for (int b = 0; b < 2; b++) begin
            bank_wr_en[b] = acc && (wr_ptr_q == 1'(b));
            bank_set[b]   = complete && (wr_ptr_q == 1'(b));
            bank_clr[b]   = drain && (rd_ptr_q == 1'(b));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            err_q    <= 1'b0;
            init_q   <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
            init_q   <= init_d;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        matrix_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .MATRIX_SIZE(MATRIX_SIZE)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (bank_wr_en[g]),
            .wr_idx  (idx_q),
            .wr_dat  (s_data),
            .set_full(bank_set[g]),
            .clr_full(bank_clr[g]),
            .mat     (bank_mat[g]),
            .full    (bank_full[g])
        );
    end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench for matrix_stream_loader: queue-based reference model checked every cycle.
module tb_matrix_stream_loader;

    localparam int DW = 8;
    localparam int MS = 25;
    localparam int MW = DW * MS;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          s_last;
    logic [MW-1:0] m_mat;
    logic          m_valid;
    logic          m_ready;
    logic          err_len;

    matrix_stream_loader #(.DATA_WIDTH(DW), .MATRIX_SIZE(MS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_data (s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_last (s_last),
        .m_mat  (m_mat),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .err_len(err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [MW-1:0] fill(input logic [7:0] v);
        logic [MW-1:0] m;
        for (int k = 0; k < MS; k++) m[k*DW +: DW] = v;
        return m;
    endfunction

    function automatic logic [7:0] ident_el(input int k);
        return ((k / 5) == (k % 5)) ? 8'd1 : 8'd0;
    endfunction

    function automatic logic [MW-1:0] ident();
        logic [MW-1:0] m;
        for (int k = 0; k < MS; k++) m[k*DW +: DW] = ident_el(k);
        return m;
    endfunction

    // Reference model: completed matrices wait in a queue of depth two; a partial
    // frame is gathered in cur[] and only becomes a matrix once 25 beats arrive.
    logic [MW-1:0] mq[$];
    logic [MW-1:0] last_dr;
    logic [MW-1:0] mdl_m;
    logic [7:0]    cur[MS];
    int            n_beats;
    bit            m_init, m_err, m_acc, m_drn;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            last_dr = '0;
            n_beats = 0;
            m_init  = 0;
            m_err   = 0;
        end else begin
            m_acc = s_valid && m_init && (mq.size() < 2);
            m_drn = (mq.size() > 0) && m_ready;
            m_err = 0;
            if (m_drn) last_dr = mq.pop_front();
            if (m_acc) begin
                cur[n_beats] = s_data;
                if (n_beats == MS - 1) begin
                    for (int k = 0; k < MS; k++) mdl_m[k*DW +: DW] = cur[k];
                    mq.push_back(mdl_m);
                    m_err   = !s_last;
                    n_beats = 0;
                end else if (s_last) begin
                    m_err   = 1;
                    n_beats = 0;
                end else begin
                    n_beats++;
                end
            end
            m_init = 1;
        end
    end

    bit            rdy_neg;
    int            err_cnt, drn_cnt, id_bad;
    logic [MW-1:0] first_mat, last_mat;

    always @(negedge clk) begin
        rdy_neg = s_ready;
        chk("s_ready", MW'(s_ready), MW'(m_init && mq.size() < 2));
        chk("m_valid", MW'(m_valid), MW'(mq.size() > 0));
        chk("err_len", MW'(err_len), MW'(m_err));
        chk("m_mat", m_mat, (mq.size() > 0) ? mq[0] : last_dr);
        if (err_len) err_cnt++;
        if (m_valid && m_ready) begin
            if (drn_cnt == 0) first_mat = m_mat;
            last_mat = m_mat;
            drn_cnt++;
            if (m_mat !== ident()) id_bad++;
        end
    end

    task automatic beat(input logic [7:0] d, input bit l);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        forever begin
            @(posedge clk);
            if (rdy_neg) break;
            n++;
            if (n > 500) begin
                n_cmp++;
                n_bad++;
                $display("FAIL beat_timeout: s_ready stayed 0 for %0d cycles, required 1", n);
                break;
            end
        end
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic frame_fill(input logic [7:0] v);
        for (int k = 0; k < MS; k++) beat(v, k == MS - 1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_cnt();
        err_cnt = 0;
        drn_cnt = 0;
        id_bad  = 0;
    endtask

    logic [MW-1:0] exp_m;

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
        clr_cnt();
        cycles(3);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_m_valid", MW'(m_valid), '0);
        chk("rst_m_mat", m_mat, '0);
        chk("rst_err", MW'(err_len), '0);
        cycles(1);
        @(negedge clk);
        chk("rst_s_ready", MW'(s_ready), MW'(1));

        // Single frame, consumer always ready
        m_ready = 1'b1;
        for (int k = 0; k < MS; k++) beat(8'(k + 1), k == MS - 1);
        @(negedge clk);
        chk("t1_valid_lat", MW'(m_valid), MW'(1));
        chk("t1_el0", MW'(m_mat[7:0]), MW'(8'h01));
        chk("t1_el24", MW'(m_mat[199:192]), MW'(8'h19));
        cycles(1);
        @(negedge clk);
        chk("t1_drained", MW'(m_valid), '0);

        // Backpressure: two frames fill both banks
        m_ready = 1'b0;
        frame_fill(8'h10);
        frame_fill(8'h20);
        @(negedge clk);
        chk("t2_stall", MW'(s_ready), '0);
        chk("t2_hold", m_mat, fill(8'h10));
        cycles(3);
        @(negedge clk);
        chk("t2_hold_stable", m_mat, fill(8'h10));
        fork
            frame_fill(8'h30);
            begin
                cycles(2);
                m_ready = 1'b1;
                cycles(1);
                m_ready = 1'b0;
                @(negedge clk);
                chk("t2_next", m_mat, fill(8'h20));
                chk("t2_ready_back", MW'(s_ready), MW'(1));
            end
        join
        m_ready = 1'b1;
        cycles(4);
        @(negedge clk);
        chk("t2_empty", MW'(m_valid), '0);

        // Early last, then a proper frame
        clr_cnt();
        for (int k = 0; k <= 10; k++) beat(8'(8'hC0 + k), k == 10);
        frame_fill(8'hAA);
        cycles(4);
        chk("t3_err_cnt", MW'(err_cnt), MW'(1));
        chk("t3_drn_cnt", MW'(drn_cnt), MW'(1));
        chk("t3_mat", last_mat, fill(8'hAA));

        // Missing last, then a proper frame
        clr_cnt();
        for (int k = 0; k < MS; k++) beat(8'h55, 1'b0);
        frame_fill(8'h66);
        cycles(4);
        chk("t4_err_cnt", MW'(err_cnt), MW'(1));
        chk("t4_drn_cnt", MW'(drn_cnt), MW'(2));
        chk("t4_first", first_mat, fill(8'h55));
        chk("t4_second", last_mat, fill(8'h66));

        // Reset with one matrix held and a partial frame in flight
        m_ready = 1'b0;
        frame_fill(8'h77);
        for (int k = 0; k < 12; k++) beat(8'h88, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_drop", MW'(m_valid), '0);
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        @(negedge clk);
        chk("t5_s_ready", MW'(s_ready), MW'(1));
        chk("t5_m_mat", m_mat, '0);
        m_ready = 1'b1;
        clr_cnt();
        for (int k = 0; k < MS; k++) begin
            exp_m[k*DW +: DW] = 8'(k + 8'h40);
            beat(8'(k + 8'h40), k == MS - 1);
        end
        cycles(2);
        chk("t5_drn_cnt", MW'(drn_cnt), MW'(1));
        chk("t5_fresh", last_mat, exp_m);

        // Identity stream with random gaps on both sides
        clr_cnt();
        fork
            begin
                for (int f = 0; f < 100; f++) begin
                    for (int k = 0; k < MS; k++) begin
                        if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 3));
                        beat(ident_el(k), k == MS - 1);
                    end
                end
            end
            begin
                for (int c = 0; c < 40000 && drn_cnt < 100; c++) begin
                    @(posedge clk);
                    #1;
                    m_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        m_ready = 1'b1;
        cycles(10);
        chk("t6_frames", MW'(drn_cnt), MW'(100));
        chk("t6_ident_bad", MW'(id_bad), '0);
        chk("t6_err", MW'(err_cnt), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/matrix_stream_loader.md
Name: matrix_stream_loader

Overview:
- Streaming front end for the determinant datapath.
- Accepts matrix elements one per beat on a valid/ready input stream, row-major.
- Packs each complete matrix into the flat MATRIX_SIZE*DATA_WIDTH bus consumed by the determinant units.
- Ping-pong double buffer, so one matrix can fill while the previous one is held for the consumer.

Parameters:
- DATA_WIDTH, 8: element width in bits.
- MATRIX_SIZE, 25: elements per matrix (5x5); also the beat count per frame.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_data  in  DATA_WIDTH  input element.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader can accept a beat.
- s_last  in  1  marks the final element of a frame.
- m_mat  out  MATRIX_SIZE*DATA_WIDTH  packed matrix; element k at bits [k*DATA_WIDTH +: DATA_WIDTH], row-major (k = row*5 + col; element 0 in the LSBs).
- m_valid  out  1  m_mat holds a complete matrix.
- m_ready  in  1  consumer accepts m_mat.
- err_len  out  1  one-cycle pulse on a frame-length violation.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - both banks empty; write index 0; write and read bank pointers 0.
  - m_valid=0, m_mat=0, err_len=0.
  - s_ready=1 from the first clock after release.
- Beat acceptance: a beat transfers when s_valid && s_ready on a rising edge.
  - s_data is written into the write bank at the current index.
  - The index increments after each write.
- s_ready = write bank not full; combinational from registered state only, with no dependence on s_valid.
- Frame completion: the beat at index MATRIX_SIZE-1 is accepted.
  - Write bank is marked full and the index returns to 0.
  - Write pointer toggles to the other bank.
  - If that bank is still full, s_ready drops until it drains.
- Output side:
  - m_valid = read bank full.
  - m_mat = read bank contents.
  - On m_valid && m_ready, the read bank is marked empty and the read pointer toggles.
- Latency: m_valid rises on the cycle after the last beat is accepted when the read bank was empty. Peak throughput is 1 beat/cycle sustained, with no bubbles between frames when the consumer keeps up.
- Stability: while m_valid && !m_ready, m_mat and m_valid hold constant.
  - When m_valid=0, m_mat shows the last drained bank's contents (0 after reset), and consumers ignore it.
- Simultaneous events:
  - A bank completing and the other bank draining in the same cycle are both honoured.
  - A drain of bank X in the same cycle that the writer is stalled on X frees X; s_ready rises the next cycle.
- Both banks full: s_ready=0 and m_valid=1 until a drain.
- Early s_last (accepted with index < MATRIX_SIZE-1):
  - the partial frame is discarded and the index returns to 0.
  - the bank stays empty, and err_len pulses on the next cycle.
- Missing s_last (index MATRIX_SIZE-1 accepted with s_last=0):
  - the matrix completes normally and err_len pulses.
  - the next beat starts a new frame.
- Elements are stored raw; no arithmetic is performed. Width handling is packing only.
- Reset mid-frame or mid-hold: all contents are invalidated immediately, and m_valid drops asynchronously with rst_n.

Decomposition:
- Shared package holds:
  - DATA_WIDTH and MATRIX_SIZE defaults.
  - the matrix dimension constant (5).
  - an index-width function clog2(MATRIX_SIZE).
  - the element-slice helper (k*DATA_WIDTH).
- One natural sub-module: matrix_bank.
  - One MATRIX_SIZE*DATA_WIDTH register with an indexed element write-enable and a full flag with set/clear.
  - Instantiated twice; the top holds the index counter, the pointers, the handshakes and the error logic.

Test Plan:
- Single frame: reset, send elements k+1 (k=0..24) back-to-back with s_last on k=24, m_ready=1.
  - Response: m_valid high exactly 1 cycle after beat 24; m_mat[7:0]=0x01, m_mat[199:192]=0x19; drained the same cycle.
- Backpressure: three frames (fill 0x10, 0x20, 0x30) with m_ready=0.
  - Frames 1 and 2 are accepted; s_ready=0 on the cycle after frame 2's last beat.
  - m_mat holds 0x10 pattern stable.
  - Pulse m_ready once: frame 2 is presented, s_ready returns 1, and frame 3 completes.
- Early last: s_last on beat 10, then a full valid frame of 0xAA.
  - Response: err_len pulses once; the only matrix output is all-0xAA; no partial matrix appears.
- Missing last: 25 beats of 0x55 with s_last=0.
  - Response: the matrix is emitted as all-0x55 and err_len pulses once.
  - The next 25 beats with proper s_last produce a second matrix with no error.
- Reset mid-frame and mid-hold: assert rst_n=0 after 12 beats with one matrix held.
  - Response: m_valid falls immediately; after release s_ready=1 and m_mat=0; a fresh frame loads correctly.
- End-to-end: stream the 5x5 identity into the loader driving a determinant unit, with random s_valid and m_ready gaps.
  - Response: det=1 on every handshake; no dropped or duplicated frames over 100 frames.
